bc_display_driver: RTL and testbench

Eight-digit seven-segment scan driver for the Bulls & Cows game on the Nexys A7. It sits directly downstream of the game FSM. On a `load` strobe it captures a display request: mode, player, 4-digit hex value and bulls/cows counts. It then time-multiplexes the eight common-anode digits, producing the board's `an` and `digit` pins. The WIN screen can optionally blink.

---
 rtl/bc_display_driver.sv | 225 ++++++++++++++++++++++
 tb/tb_bc_display_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bc_display_driver.sv
// -----------------------------------------------------------------------------
// bc_display_driver
// Eight-digit seven-segment scan driver for the Bulls & Cows game (Nexys A7).
// A load strobe captures a display request into shadow registers; the driver
// then time-multiplexes the eight common-anode digits from those shadows.
//
// Parameters:
//   SCAN_DIV   clock cycles each anode stays active (>= 2)
//   BLINK_DIV  clock cycles per WIN blink half-period (>= 2, blink build only)
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   load_i     capture mode/player/value/bulls/cows on this edge
//   mode_i     0 BLANK, 1 SETUP, 2 GUESS, 3 RESULT, 4 WIN, 5..7 BLANK
//   player_i   0 = player 1, 1 = player 2
//   value_i    four hex digits, [15:12] leftmost
//   bulls_i    bulls count
//   cows_i     cows count
//   an_o       anode enables, active-low, an_o[7] leftmost
//   digit_o    segments {g,f,e,d,c,b,a}, active-low
//
// Build option:
//   BC_DISP_BLINK_EN  when defined, the WIN screen blinks. Blink phase FSM:
//     state  | meaning
//     PH_ON  | WIN screen lit
//     PH_OFF | WIN screen dark (an_o = FF, digit_o = 7F)
// -----------------------------------------------------------------------------
module bc_display_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic [2:0]  mode_i,
    input  logic        player_i,
    input  logic [15:0] value_i,
    input  logic [2:0]  bulls_i,
    input  logic [2:0]  cows_i,
    output logic [7:0]  an_o,
    output logic [6:0]  digit_o
);

    typedef enum logic [2:0] {
        MODE_BLANK  = 3'd0,
        MODE_SETUP  = 3'd1,
        MODE_GUESS  = 3'd2,
        MODE_RESULT = 3'd3,
        MODE_WIN    = 3'd4
    } mode_e;

    localparam logic [6:0] G_P     = 7'h0C;
    localparam logic [6:0] G_B     = 7'h03;
    localparam logic [6:0] G_C     = 7'h27;
    localparam logic [6:0] G_G     = 7'h42;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_params
        $error("bc_display_driver: SCAN_DIV and BLINK_DIV must be >= 2");
    end

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    logic [2:0]        mode_q;
    logic              player_q;
    logic [15:0]       value_q;
    logic [2:0]        bulls_q;
    logic [2:0]        cows_q;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        digit_q, digit_d;
    logic              blink_dark;

    // Scan counter and digit index: free-running, untouched by load.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_ONE;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end
    end

`ifdef BC_DISP_BLINK_EN
    typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    phase_e             phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        phase_d     = phase_q;
        // Only an entry into WIN restarts the blink; re-loading WIN keeps phase.
        if (load_i && (mode_i == MODE_WIN) && (mode_q != MODE_WIN)) begin
            blink_cnt_d = '0;
            phase_d     = PH_ON;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_dark = (mode_q == MODE_WIN) && (phase_q == PH_OFF);
`else
    assign blink_dark = 1'b0;
`endif

    // Screen content for the current position, built from shadows only.
    logic [6:0] player_glyph;
    logic [3:0] val_nib;

    always_comb begin
        player_glyph = player_q ? hex_glyph(4'h2) : hex_glyph(4'h1);
        val_nib      = value_q[{idx_q[1:0], 2'b00} +: 4];
        digit_d      = G_BLANK;
        case (mode_q)
            MODE_SETUP, MODE_GUESS: begin
                case (idx_q)
                    3'd7:    digit_d = G_P;
                    3'd6:    digit_d = player_glyph;
                    3'd5:    digit_d = (mode_q == MODE_SETUP) ? G_DASH : G_BLANK;
                    3'd4:    digit_d = G_BLANK;
                    default: digit_d = hex_glyph(val_nib);
                endcase
            end
            MODE_RESULT: begin
                case (idx_q)
                    3'd7:    digit_d = G_B;
                    3'd6:    digit_d = hex_glyph({1'b0, bulls_q});
                    3'd3:    digit_d = G_C;
                    3'd2:    digit_d = hex_glyph({1'b0, cows_q});
                    default: digit_d = G_BLANK;
                endcase
            end
            MODE_WIN: begin
                case (idx_q)
                    3'd7:       digit_d = G_P;
                    3'd6:       digit_d = player_glyph;
                    3'd3:       digit_d = G_G;
                    3'd2, 3'd1: digit_d = hex_glyph(4'h0);
                    3'd0:       digit_d = G_D;
                    default:    digit_d = G_BLANK;
                endcase
            end
            default: digit_d = G_BLANK;
        endcase

        an_d = ~(8'h01 << idx_q);
        if (blink_dark) begin
            an_d    = 8'hFF;
            digit_d = G_BLANK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_BLANK;
            player_q   <= 1'b0;
            value_q    <= '0;
            bulls_q    <= '0;
            cows_q     <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= 8'hFF;
            digit_q    <= G_BLANK;
        end else begin
            if (load_i) begin
                mode_q   <= mode_i;
                player_q <= player_i;
                value_q  <= value_i;
                bulls_q  <= bulls_i;
                cows_q   <= cows_i;
            end
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            digit_q    <= digit_d;
        end
    end

    assign an_o    = an_q;
    assign digit_o = digit_q;

endmodule

// File: tb/tb_bc_display_driver.sv
module tb_bc_display_driver;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
`ifdef BC_DISP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_i = 1'b0;
    logic [2:0]  mode_i = '0;
    logic        player_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [2:0]  bulls_i = '0;
    logic [2:0]  cows_i = '0;
    logic [7:0]  an_o;
    logic [6:0]  digit_o;

    always #5 clock = ~clock;

    bc_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clock(clock), .reset(reset), .load_i(load_i), .mode_i(mode_i),
        .player_i(player_i), .value_i(value_i), .bulls_i(bulls_i),
        .cows_i(cows_i), .an_o(an_o), .digit_o(digit_o)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] dg;
    } exp_t;
    exp_t sb_q[$];

    logic [6:0] hexg [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // Tables indexed by position 0 (rightmost) .. 7
    logic [6:0] setup_tab  [0:7] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h3F, 7'h79, 7'h0C};
    logic [6:0] result_tab [0:7] = '{7'h7F, 7'h7F, 7'h79, 7'h27, 7'h7F, 7'h7F, 7'h24, 7'h03};
    logic [6:0] guess_tab  [0:7] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h7F, 7'h7F, 7'h79, 7'h0C};
    logic [6:0] seen [0:7];

    // Reference model state
    int         m_cnt, m_idx, m_bcnt;
    bit         m_off;
    logic [2:0] m_mode;
    logic       m_player;
    logic [15:0] m_val;
    logic [2:0] m_b, m_c;

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_bcnt = 0; m_off = 1'b0;
        m_mode = 3'd0; m_player = 1'b0; m_val = '0; m_b = '0; m_c = '0;
        sb_q.delete();
    endtask

    function automatic logic [6:0] model_glyph(input int p);
        logic [6:0] scr [0:7];
        logic [6:0] n;
        n = m_player ? hexg[2] : hexg[1];
        for (int i = 0; i < 8; i++) scr[i] = 7'h7F;
        case (m_mode)
            3'd1, 3'd2: begin
                scr[7] = 7'h0C; scr[6] = n;
                if (m_mode == 3'd1) scr[5] = 7'h3F;
                scr[3] = hexg[m_val[15:12]]; scr[2] = hexg[m_val[11:8]];
                scr[1] = hexg[m_val[7:4]];   scr[0] = hexg[m_val[3:0]];
            end
            3'd3: begin
                scr[7] = 7'h03; scr[6] = hexg[{1'b0, m_b}];
                scr[3] = 7'h27; scr[2] = hexg[{1'b0, m_c}];
            end
            3'd4: begin
                scr[7] = 7'h0C; scr[6] = n; scr[3] = 7'h42;
                scr[2] = 7'h40; scr[1] = 7'h40; scr[0] = 7'h21;
            end
            default: ;
        endcase
        return scr[p];
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One clock: drive inputs, push the output expected at this edge, advance
    // the model, then pop and compare just after the edge.
    task automatic step(input bit ld, input logic [2:0] md, input logic pl,
                        input logic [15:0] v, input logic [2:0] b, input logic [2:0] c);
        exp_t e;
        exp_t got_e;
        bit restart;
        load_i = ld; mode_i = md; player_i = pl; value_i = v; bulls_i = b; cows_i = c;
        if (BLINK_ON && m_mode == 3'd4 && m_off) begin
            e.an = 8'hFF; e.dg = 7'h7F;
        end else begin
            e.an = 8'hFF ^ (8'h01 << m_idx);
            e.dg = model_glyph(m_idx);
        end
        sb_q.push_back(e);
        restart = ld && (md == 3'd4) && (m_mode != 3'd4);
        if (restart) begin
            m_bcnt = 0; m_off = 1'b0;
        end else if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt = 0; m_off = ~m_off;
        end else begin
            m_bcnt++;
        end
        if (ld) begin
            m_mode = md; m_player = pl; m_val = v; m_b = b; m_c = c;
        end
        if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0; m_idx = (m_idx + 1) % 8;
        end else begin
            m_cnt++;
        end
        @(posedge clock);
        #1;
        load_i = 1'b0;
        got_e = sb_q.pop_front();
        total++;
        assert (an_o === got_e.an && digit_o === got_e.dg) else begin
            bad++;
            $error("FAIL scan: an=%h digit=%h expected an=%h digit=%h",
                   an_o, digit_o, got_e.an, got_e.dg);
        end
        for (int p = 0; p < 8; p++)
            if (an_o == (8'hFF ^ (8'h01 << p))) seen[p] = digit_o;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 16'h0, 3'd0, 3'd0);
    endtask

    task automatic clear_seen();
        for (int p = 0; p < 8; p++) seen[p] = 7'h55;
    endtask

    initial begin
        int old_idx, new_idx, lit, dark;
        bit found;
        model_reset();

        // Reset
        #2 reset = 1'b1;
        #1;
        chk("rst_an", an_o, 8'hFF);
        chk("rst_digit", {1'b0, digit_o}, 8'h7F);
        @(posedge clock); @(posedge clock); #1;
        chk("rst_hold_an", an_o, 8'hFF);
        reset = 1'b0;
        model_reset();
        idle();
        chk("first_an", an_o, 8'hFE);
        chk("first_digit", {1'b0, digit_o}, 8'h7F);
        for (int i = 0; i < 3; i++) idle();
        chk("dwell_end_an", an_o, 8'hFE);
        idle();
        chk("step_an", an_o, 8'hFD);
        for (int i = 0; i < 27; i++) idle();
        chk("last_an", an_o, 8'h7F);
        idle();
        chk("wrap_an", an_o, 8'hFE);

        // SETUP
        step(1'b1, 3'd1, 1'b0, 16'h1234, 3'd0, 3'd0);
        clear_seen();
        for (int i = 0; i < 8 * SCAN_DIV; i++) idle();
        for (int p = 0; p < 8; p++) chk($sformatf("setup_p%0d", p), {1'b0, seen[p]}, {1'b0, setup_tab[p]});

        // RESULT, then unused mode
        step(1'b1, 3'd3, 1'b0, 16'h0, 3'd2, 3'd1);
        clear_seen();
        for (int i = 0; i < 8 * SCAN_DIV; i++) idle();
        for (int p = 0; p < 8; p++) chk($sformatf("result_p%0d", p), {1'b0, seen[p]}, {1'b0, result_tab[p]});
        step(1'b1, 3'd6, 1'b1, 16'hFFFF, 3'd7, 3'd7);
        clear_seen();
        for (int i = 0; i < 8 * SCAN_DIV; i++) idle();
        for (int p = 0; p < 8; p++) chk($sformatf("mode6_p%0d", p), {1'b0, seen[p]}, 8'h7F);

        // Load coinciding with a scan wrap
        for (int i = 0; i < SCAN_DIV && m_cnt != SCAN_DIV - 1; i++) idle();
        old_idx = m_idx;
        new_idx = (m_idx + 1) % 8;
        step(1'b1, 3'd2, 1'b0, 16'hABCD, 3'd0, 3'd0);
        chk("wrapld_old_an", an_o, 8'hFF ^ (8'h01 << old_idx));
        chk("wrapld_old_digit", {1'b0, digit_o}, 8'h7F);
        idle();
        chk("wrapld_new_an", an_o, 8'hFF ^ (8'h01 << new_idx));
        chk("wrapld_new_digit", {1'b0, digit_o}, {1'b0, guess_tab[new_idx]});

        // WIN blink
        step(1'b1, 3'd4, 1'b1, 16'h0, 3'd0, 3'd0);
        lit = 0; dark = 0;
        for (int i = 0; i < BLINK_DIV; i++) begin idle(); if (an_o != 8'hFF) lit++; end
        for (int i = 0; i < BLINK_DIV; i++) begin idle(); if (an_o == 8'hFF) dark++; end
        chk("win_lit", 8'(lit), 8'(BLINK_DIV));
        chk("win_dark", 8'(dark), BLINK_ON ? 8'(BLINK_DIV) : 8'd0);
        for (int i = 0; i < BLINK_DIV + 4; i++) idle();
        step(1'b1, 3'd4, 1'b1, 16'h0, 3'd0, 3'd0);
        dark = 0;
        for (int i = 0; i < 11; i++) begin idle(); if (an_o == 8'hFF) dark++; end
        chk("reload_dark", 8'(dark), BLINK_ON ? 8'd11 : 8'd0);
        idle();
        chk("reload_relit", {7'b0, an_o != 8'hFF}, 8'h01);

        // Async reset mid-frame in RESULT
        step(1'b1, 3'd3, 1'b0, 16'h0, 3'd2, 3'd1);
        found = 1'b0;
        for (int i = 0; i < 10 * SCAN_DIV && !found; i++) begin
            idle();
            if (an_o == 8'hDF) found = 1'b1;
        end
        chk("reach_idx5", {7'b0, found}, 8'h01);
        #2 reset = 1'b1;
        #1;
        chk("midrst_an", an_o, 8'hFF);
        chk("midrst_digit", {1'b0, digit_o}, 8'h7F);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        clear_seen();
        idle();
        chk("postrst_an", an_o, 8'hFE);
        for (int i = 1; i < 8 * SCAN_DIV; i++) idle();
        for (int p = 0; p < 8; p++) chk($sformatf("postrst_p%0d", p), {1'b0, seen[p]}, 8'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
